// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the serial expression recognizer.
package expr_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NUM  = 3'd1,
        S_OPER = 3'd2,
        S_RPAR = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CC_DIG = 3'd0,
        CC_OP  = 3'd1,
        CC_LP  = 3'd2,
        CC_RP  = 3'd3,
        CC_BAD = 3'd4
    } char_class_t;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_LP    = 8'h28;
    localparam logic [7:0] ASC_RP    = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier; disabled operators fall into the BAD class.
module expr_char_class
    import expr_pkg::*;
#(
    parameter bit ALLOW_SUB = 1'b1,
    parameter bit ALLOW_DIV = 1'b1
) (
    input  logic [7:0] i_char,
    output logic [2:0] o_class
);

    always_comb begin
        o_class = CC_BAD;
        if (i_char >= ASC_0 && i_char <= ASC_9) begin
            o_class = CC_DIG;
        end else if (i_char == ASC_PLUS || i_char == ASC_STAR) begin
            o_class = CC_OP;
        end else if (ALLOW_SUB && i_char == ASC_MINUS) begin
            o_class = CC_OP;
        end else if (ALLOW_DIV && i_char == ASC_SLASH) begin
            o_class = CC_OP;
        end else if (i_char == ASC_LP) begin
            o_class = CC_LP;
        end else if (i_char == ASC_RP) begin
            o_class = CC_RP;
        end
    end

endmodule

// File: rtl/expr_recognizer.sv
// Serial recognizer for arithmetic expressions with multi-digit operands and nested parentheses.
// Input handshake: a character is consumed on every rising edge where in_valid=1; there is no ready.
module expr_recognizer
    import expr_pkg::*;
#(
    parameter int unsigned DEPTH_W    = 3,
    parameter int unsigned MAX_DIGITS = 4,
    parameter bit          ALLOW_SUB  = 1'b1,
    parameter bit          ALLOW_DIV  = 1'b1
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               restart,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [7:0]         op_cnt,
    output logic [2:0]         dbg_state
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [3:0]         DIG_MAX   = 4'(MAX_DIGITS);

    state_t             r_state;
    logic [3:0]         r_dig_cnt;
    logic [DEPTH_W-1:0] r_depth;
    logic [7:0]         r_op_cnt;

    state_t             w_state_nxt;
    logic [3:0]         w_dig_cnt_nxt;
    logic [DEPTH_W-1:0] w_depth_nxt;
    logic [7:0]         w_op_cnt_nxt;
    logic [7:0]         w_op_inc;
    logic [2:0]         w_class_raw;
    char_class_t        w_class;

    expr_char_class #(
        .ALLOW_SUB (ALLOW_SUB),
        .ALLOW_DIV (ALLOW_DIV)
    ) u_char_class (
        .i_char  (in),
        .o_class (w_class_raw)
    );

    assign w_class  = char_class_t'(w_class_raw);
    assign w_op_inc = (r_op_cnt == 8'hFF) ? r_op_cnt : r_op_cnt + 8'd1;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_IDLE;
            r_dig_cnt <= 4'd0;
            r_depth   <= '0;
            r_op_cnt  <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_dig_cnt <= w_dig_cnt_nxt;
            r_depth   <= w_depth_nxt;
            r_op_cnt  <= w_op_cnt_nxt;
        end
    end

    // Any path into S_ERR leaves the counters at their defaults, which freezes them.
    always_comb begin
        w_state_nxt   = r_state;
        w_dig_cnt_nxt = r_dig_cnt;
        w_depth_nxt   = r_depth;
        w_op_cnt_nxt  = r_op_cnt;
        if (restart) begin
            w_state_nxt   = S_IDLE;
            w_dig_cnt_nxt = 4'd0;
            w_depth_nxt   = '0;
            w_op_cnt_nxt  = 8'd0;
        end else if (in_valid) begin
            case (r_state)
                S_IDLE, S_OPER: begin
                    case (w_class)
                        CC_DIG: begin
                            w_state_nxt   = S_NUM;
                            w_dig_cnt_nxt = 4'd1;
                        end
                        CC_LP: begin
                            if (r_depth == DEPTH_MAX) begin
                                w_state_nxt = S_ERR;
                            end else begin
                                w_state_nxt = S_OPER;
                                w_depth_nxt = r_depth + 1'b1;
                            end
                        end
                        default: w_state_nxt = S_ERR;
                    endcase
                end
                S_NUM: begin
                    case (w_class)
                        CC_DIG: begin
                            if (r_dig_cnt == DIG_MAX) begin
                                w_state_nxt = S_ERR;
                            end else begin
                                w_dig_cnt_nxt = r_dig_cnt + 4'd1;
                            end
                        end
                        CC_OP: begin
                            w_state_nxt  = S_OPER;
                            w_op_cnt_nxt = w_op_inc;
                        end
                        CC_RP: begin
                            if (r_depth == '0) begin
                                w_state_nxt = S_ERR;
                            end else begin
                                w_state_nxt = S_RPAR;
                                w_depth_nxt = r_depth - 1'b1;
                            end
                        end
                        default: w_state_nxt = S_ERR;
                    endcase
                end
                S_RPAR: begin
                    case (w_class)
                        CC_OP: begin
                            w_state_nxt  = S_OPER;
                            w_op_cnt_nxt = w_op_inc;
                        end
                        CC_RP: begin
                            if (r_depth == '0) begin
                                w_state_nxt = S_ERR;
                            end else begin
                                w_depth_nxt = r_depth - 1'b1;
                            end
                        end
                        default: w_state_nxt = S_ERR;
                    endcase
                end
                default: w_state_nxt = S_ERR;
            endcase
        end
    end

    always_comb begin
        err       = (r_state == S_ERR);
        out       = ((r_state == S_NUM) || (r_state == S_RPAR)) && (r_depth == '0);
        depth     = r_depth;
        op_cnt    = r_op_cnt;
        dbg_state = r_state;
    end

endmodule
